// File: rtl/fetch_if.sv
// Bundle between the fetch unit and its sequencer/memory/datapath neighbours.
// The slave modport is the fetch unit; master is the surrounding CPU side.
interface fetch_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic [2:0]    cs;
    logic [DW-1:0] mem_rdata;
    logic          pc_load;
    logic [AW-1:0] pc_target;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    logic          halt;
    logic          cont;
    logic          ill;
    logic [15:0]   icount;

    modport master (
        output cs, mem_rdata, pc_load, pc_target,
        input  mem_addr, pc, ir, halt, cont, ill, icount
    );

    modport slave (
        input  cs, mem_rdata, pc_load, pc_target,
        output mem_addr, pc, ir, halt, cont, ill, icount
    );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: holds pc/ir/icount, muxes the memory address, decodes halt/cont/ill.
// Latency: ir valid 2 cycles after FETCHA; halt/cont combinational in EXECA; pc_load -> pc in 1 edge.
// Backpressure: none; the sequencer state paces every register update.
module fetch #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.slave bus
);
    localparam logic [2:0] CS_IDLE   = 3'd0;
    localparam logic [2:0] CS_FETCHA = 3'd1;
    localparam logic [2:0] CS_FETCHB = 3'd2;
    localparam logic [2:0] CS_EXECA  = 3'd3;
    localparam logic [2:0] CS_EXECB  = 3'd4;

    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_ILL  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [AW-1:0] pc_q;
    logic [DW-1:0] ir_q;
    logic [15:0]   icount_q;
    logic          ill_q;
    logic [3:0]    opcode;
    logic          in_exec;

    assign opcode  = ir_q[DW-1:DW-4];
    assign in_exec = (bus.cs == CS_EXECA) || (bus.cs == CS_EXECB);

    // Execute phases address the operand; everything else (including bad cs codes) addresses pc.
    always_comb begin
        bus.mem_addr = pc_q;
        if (in_exec)
            bus.mem_addr = ir_q[AW-1:0];
    end

    always_comb begin
        bus.halt = 1'b0;
        bus.cont = 1'b0;
        if (bus.cs == CS_EXECA) begin
            bus.halt = (opcode == OP_HALT) || (opcode == OP_ILL);
            bus.cont = (opcode == OP_LD) || (opcode == OP_ST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= '0;
            ir_q     <= '0;
            icount_q <= '0;
            ill_q    <= 1'b0;
        end else begin
            if (bus.cs == CS_FETCHB) begin
                ir_q     <= bus.mem_rdata;
                pc_q     <= pc_q + AW'(1);
                icount_q <= icount_q + 16'd1;
            end
            if (in_exec && bus.pc_load)
                pc_q <= bus.pc_target;
            if ((bus.cs == CS_EXECA) && (opcode == OP_ILL))
                ill_q <= 1'b1;
        end
    end

    assign bus.pc     = pc_q;
    assign bus.ir     = ir_q;
    assign bus.icount = icount_q;
    assign bus.ill    = ill_q;
endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: table of instructions run through FETCHA/FETCHB/EXECA/EXECB with a
// scoreboard of expected EXECA state, plus hand sequences for icount wrap and async reset.
module tb_fetch;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCHA = 3'd1;
    localparam logic [2:0] FETCHB = 3'd2;
    localparam logic [2:0] EXECA  = 3'd3;
    localparam logic [2:0] EXECB  = 3'd4;

    logic clk;
    logic reset;
    fetch_if #(.AW(12), .DW(16)) bus ();

    fetch #(.AW(12), .DW(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [4096];
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

    typedef struct {
        logic [15:0] ir;
        logic [11:0] pc;
        logic [15:0] icount;
        logic        halt;
        logic        cont;
        logic [11:0] addr;
    } exp_t;

    // jph: 0 none, 1 pc_load in FETCHA (ignored), 2 in EXECB, 3 in EXECA (tgt) and EXECB (tgt+1)
    typedef struct {
        logic [15:0] word;
        int          jph;
        logic [11:0] tgt;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    int checks = 0;
    int errors = 0;

    logic [11:0] m_pc;
    logic [15:0] m_icount;
    logic        m_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic ld, input logic [11:0] tgt);
        bus.cs        = c;
        bus.pc_load   = ld;
        bus.pc_target = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input vec_t v);
        exp_t e;
        logic [3:0] opc;
        opc = v.word[15:12];
        mem[m_pc] = v.word;

        drive(FETCHA, v.jph == 1, v.tgt);
        @(negedge clk);
        chk("fa_addr", 32'(bus.mem_addr), 32'(m_pc));
        chk("fa_flags", {bus.halt, bus.cont}, 2'b00);
        e.ir     = v.word;
        e.pc     = m_pc + 12'd1;
        e.icount = m_icount + 16'd1;
        e.halt   = (opc == 4'hF) || (opc == 4'hE);
        e.cont   = (opc == 4'h8) || (opc == 4'h9);
        e.addr   = v.word[11:0];
        sb.push_back(e);
        tick();

        drive(FETCHB, 1'b0, 12'h0);
        @(negedge clk);
        chk("fb_pc", 32'(bus.pc), 32'(m_pc));
        tick();
        m_pc     = m_pc + 12'd1;
        m_icount = m_icount + 16'd1;

        drive(EXECA, v.jph == 3, v.tgt);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("ea_ir", 32'(bus.ir), 32'(e.ir));
            chk("ea_pc", 32'(bus.pc), 32'(e.pc));
            chk("ea_icount", 32'(bus.icount), 32'(e.icount));
            chk("ea_halt", 32'(bus.halt), 32'(e.halt));
            chk("ea_cont", 32'(bus.cont), 32'(e.cont));
            chk("ea_addr", 32'(bus.mem_addr), 32'(e.addr));
            chk("ea_ill", 32'(bus.ill), 32'(m_ill));
        end
        tick();
        if (opc == 4'hE) m_ill = 1'b1;
        if (v.jph == 3) m_pc = v.tgt;

        if (((opc == 4'h8) || (opc == 4'h9)) || v.jph >= 2) begin
            drive(EXECB, v.jph >= 2, (v.jph == 3) ? v.tgt + 12'd1 : v.tgt);
            @(negedge clk);
            chk("eb_pc", 32'(bus.pc), 32'(m_pc));
            chk("eb_flags", {bus.halt, bus.cont}, 2'b00);
            chk("eb_addr", 32'(bus.mem_addr), 32'(v.word[11:0]));
            tick();
            if (v.jph >= 2) m_pc = (v.jph == 3) ? v.tgt + 12'd1 : v.tgt;
        end

        drive(IDLE, 1'b1, 12'h777);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("idle_pc", 32'(bus.pc), 32'(m_pc));
        chk("idle_icount", 32'(bus.icount), 32'(m_icount));
        chk("idle_ill", 32'(bus.ill), 32'(m_ill));
        chk("idle_ir", 32'(bus.ir), 32'(v.word));
        chk("idle_flags", {bus.halt, bus.cont}, 2'b00);
        tick();
    endtask

    initial begin
        vecs[0] = '{16'h1234, 0, 12'h000};
        vecs[1] = '{16'h2000, 0, 12'h000};
        vecs[2] = '{16'h8055, 0, 12'h000};
        vecs[3] = '{16'h9123, 1, 12'h555};
        vecs[4] = '{16'hF000, 0, 12'h000};
        vecs[5] = '{16'h0ABC, 2, 12'h3A0};
        vecs[6] = '{16'h7001, 3, 12'hFFE};
        vecs[7] = '{16'h3003, 0, 12'h000};
        vecs[8] = '{16'hE000, 0, 12'h000};
        vecs[9] = '{16'h1111, 0, 12'h000};

        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        m_pc = 12'h0; m_icount = 16'h0; m_ill = 1'b0;

        reset = 1'b0;
        drive(IDLE, 1'b0, 12'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", 32'(bus.pc), 32'h0);
        chk("rst_ir", 32'(bus.ir), 32'h0);
        chk("rst_icount", 32'(bus.icount), 32'h0);
        chk("rst_ill", 32'(bus.ill), 32'h0);
        chk("rst_flags", {bus.halt, bus.cont}, 2'b00);
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_instr(vecs[i]);

        // Back-to-back FETCHB edges each count, so icount can be walked to its wrap point.
        begin
            int n;
            n = 65535 - int'(m_icount);
            drive(FETCHB, 1'b0, 12'h0);
            repeat (n) @(posedge clk);
            #1;
            m_pc     = m_pc + 12'(n);
            m_icount = 16'hFFFF;
            @(negedge clk);
            chk("icount_max", 32'(bus.icount), 32'hFFFF);
            chk("icount_pc", 32'(bus.pc), 32'(m_pc));
            tick();
            drive(IDLE, 1'b0, 12'h0);
            @(negedge clk);
            chk("icount_wrap", 32'(bus.icount), 32'h0);
            chk("icount_ill", 32'(bus.ill), 32'h1);
            tick();
            m_pc = m_pc + 12'd1;
        end

        // Async reset while a HALT is decoding in EXECA.
        mem[m_pc] = 16'hF000;
        drive(FETCHA, 1'b0, 12'h0); tick();
        drive(FETCHB, 1'b0, 12'h0); tick();
        drive(EXECA, 1'b0, 12'h0);
        @(negedge clk);
        chk("ar_halt_before", 32'(bus.halt), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_halt", 32'(bus.halt), 32'h0);
        chk("ar_pc", 32'(bus.pc), 32'h0);
        chk("ar_ir", 32'(bus.ir), 32'h0);
        chk("ar_icount", 32'(bus.icount), 32'h0);
        chk("ar_ill", 32'(bus.ill), 32'h0);
        drive(IDLE, 1'b0, 12'h0);
        tick();
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
